// File: rtl/icache_line_fill_if.sv
// rtl/icache_line_fill_if.sv - I-cache line-fill and word-memory signal bundle
interface icache_line_fill_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 256
);
    logic                  c_strobe_i;
    logic [ADDR_WIDTH-1:0] c_addr_i;
    logic                  c_ready_o;
    logic [LINE_SIZE-1:0]  c_data_o;
    logic                  w_req_o;
    logic [ADDR_WIDTH-1:0] w_addr_o;
    logic                  w_valid_i;
    logic [DATA_WIDTH-1:0] w_data_i;

    // Fill engine side
    modport slave (
        input  c_strobe_i, c_addr_i, w_valid_i, w_data_i,
        output c_ready_o, c_data_o, w_req_o, w_addr_o
    );

    // Cache + memory environment side
    modport master (
        output c_strobe_i, c_addr_i, w_valid_i, w_data_i,
        input  c_ready_o, c_data_o, w_req_o, w_addr_o
    );
endinterface

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - line-fill responder, optional stats via ICACHE_FILL_STATS_EN
module icache_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    icache_line_fill_if.slave    bus
`ifdef ICACHE_FILL_STATS_EN
    ,
    output logic [31:0]          fill_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);
    localparam int WORDS   = LINE_SIZE / DATA_WIDTH;
    localparam int K_W     = $clog2(WORDS);
    localparam int BYTES_W = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_SIZE / 8 - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LINE_SIZE-1:0]  line_q;
    logic                  line_we;
    logic                  ready_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

    // Next-state, word index and line base for the fill sequence
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        line_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.c_strobe_i) begin
                    base_d  = bus.c_addr_i & ~LINE_MASK;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.w_valid_i) begin
                    line_we = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = S_RESP;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Wraps modulo 2^ADDR_WIDTH; the base is line-aligned so words stay inside the line
        waddr_d = base_d + (ADDR_WIDTH'(k_d) << BYTES_W);
    end

    // State, counters and registered outputs; outputs lead the state they belong to
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            line_q  <= '0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            ready_q <= (state_d == S_RESP);
            req_q   <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) begin
                waddr_q <= waddr_d;
            end
            if (line_we) begin
                line_q[(WORDS - 1 - int'(k_q)) * DATA_WIDTH +: DATA_WIDTH] <= bus.w_data_i;
            end
        end
    end

    assign bus.c_ready_o = ready_q;
    assign bus.c_data_o  = line_q;
    assign bus.w_req_o   = req_q;
    assign bus.w_addr_o  = waddr_q;

`ifdef ICACHE_FILL_STATS_EN
    logic [31:0] fill_cnt_q;
    logic [31:0] stall_cnt_q;

    // Free-running wrap-around counters of completed fills and busy cycles
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fill_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == S_RESP) begin
                fill_cnt_q <= fill_cnt_q + 32'd1;
            end
            if (state_q == S_ISSUE || state_q == S_WAIT) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fill_cnt_o  = fill_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - self-checking bench for icache_line_fill
module tb_icache_line_fill;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LS    = 256;
    localparam int WORDS = LS / DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    icache_line_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_SIZE(LS)) bus ();

`ifdef ICACHE_FILL_STATS_EN
    logic [31:0] fill_cnt;
    logic [31:0] stall_cnt;
`endif

    icache_line_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_SIZE(LS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef ICACHE_FILL_STATS_EN
        ,
        .fill_cnt_o  (fill_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory contents: every word is its own address scrambled by a per-fill key
    logic [31:0] key = 32'h0;
    int          max_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    // Word memory: answer each request after 1 + random(0..max_delay) cycles
    bit          pend = 1'b0;
    int          dly;
    logic [31:0] paddr;
    initial begin
        bus.w_valid_i = 1'b0;
        bus.w_data_i  = '0;
    end
    always @(negedge clk) begin
        bus.w_valid_i = 1'b0;
        if (pend) begin
            if (dly == 0) begin
                bus.w_valid_i = 1'b1;
                bus.w_data_i  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                dly--;
            end
        end
        if (bus.w_req_o === 1'b1) begin
            pend  = 1'b1;
            paddr = bus.w_addr_o;
            dly   = $urandom_range(0, max_delay);
        end
    end

    // Observed requests and line responses
    logic [31:0]  req_addrs[$];
    int           ready_cnt = 0;
    logic [255:0] line_cap = '0;
    always @(negedge clk) begin
        if (bus.w_req_o === 1'b1) req_addrs.push_back(bus.w_addr_o);
        if (bus.c_ready_o === 1'b1) begin
            ready_cnt++;
            line_cap = bus.c_data_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One complete fill, strobe held through RESP and dropped the cycle after ready
    task automatic fill(input logic [31:0] addr, input logic [31:0] exp_base,
                        input int exp_lat, input bit settle, input string tag);
        logic [255:0] exp_line;
        int           lat;
        bit           ok;
        req_addrs.delete();
        ready_cnt = 0;
        bus.c_strobe_i = 1'b1;
        bus.c_addr_i   = addr;
        lat = 0;
        while (ready_cnt == 0 && lat < 500) begin
            step();
            lat++;
        end
        step();
        bus.c_strobe_i = 1'b0;
        bus.c_addr_i   = $urandom;
        if (settle) repeat (3) step();
        for (int k = 0; k < WORDS; k++)
            exp_line[LS-1-k*DW -: DW] = mem_word(exp_base + 32'(4 * k));
        check({tag, " ready_pulses"}, 256'(ready_cnt), 256'(1));
        check({tag, " req_count"}, 256'(req_addrs.size()), 256'(WORDS));
        ok = (req_addrs.size() == WORDS);
        for (int k = 0; k < WORDS && ok; k++)
            if (req_addrs[k] !== exp_base + 32'(4 * k)) ok = 1'b0;
        check({tag, " req_addrs"}, 256'(ok), 256'(1));
        check({tag, " line"}, line_cap, exp_line);
        if (exp_lat > 0) check({tag, " latency"}, 256'(lat), 256'(exp_lat));
        else             check({tag, " latency_min"}, 256'(lat >= 2 * WORDS + 1), 256'(1));
    endtask

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [31:0] exp_base;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] a;
        int          guard;

        vecs[0] = '{32'h8000_0044, 0, 32'h8000_0040, 17};
        vecs[1] = '{32'hFFFF_FFFF, 0, 32'hFFFF_FFE0, 17};
        vecs[2] = '{32'h0000_001F, 0, 32'h0000_0000, 17};
        vecs[3] = '{32'h8000_0044, 5, 32'h8000_0040, 0};
        vecs[4] = '{32'h1234_5678, 3, 32'h1234_5660, 0};

        // Reset held with strobe high: everything stays quiet
        rst_n = 1'b0;
        bus.c_strobe_i = 1'b1;
        bus.c_addr_i   = 32'h8000_0044;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_outputs_%0d", i),
                  {bus.c_ready_o, bus.w_req_o, bus.w_addr_o, bus.c_data_o[222:0]}, '0);
        end
        check("reset_data_hi", 256'(bus.c_data_o[255:223]), 256'(0));
        req_addrs.delete();
        rst_n = 1'b1;
        step();
        check("accept_after_reset", {bus.w_req_o, bus.w_addr_o}, {1'b1, 32'h8000_0040});
        rst_n = 1'b0;
        bus.c_strobe_i = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Directed vectors including alignment and wrap boundaries
        for (int i = 0; i < 5; i++) begin
            max_delay = vecs[i].delay;
            key = (i == 0) ? 32'h0 : $urandom;
            fill(vecs[i].addr, vecs[i].exp_base, vecs[i].exp_lat, 1'b1, $sformatf("vec%0d", i));
        end

        // Randomized fills against the address/line model
        max_delay = 5;
        for (int i = 0; i < 12; i++) begin
            a   = $urandom;
            key = $urandom;
            fill(a, a & ~32'h1F, 0, 1'b1, $sformatf("rnd%0d", i));
        end

        // Back-to-back: second request raised as soon as the engine is idle again
        max_delay = 0;
        key = 32'h5A5A_0000;
        fill(32'h8000_0000, 32'h8000_0000, 17, 1'b0, "b2b_first");
        key = 32'h0F0F_F0F0;
        fill(32'h8000_0100, 32'h8000_0100, 17, 1'b1, "b2b_second");

        // Abort mid-fill after three words, then a fresh fill
        key = 32'h0;
        req_addrs.delete();
        ready_cnt = 0;
        bus.c_strobe_i = 1'b1;
        bus.c_addr_i   = 32'h8000_0040;
        guard = 0;
        while (req_addrs.size() < 4 && guard < 100) begin
            step();
            guard++;
        end
        check("abort_reached_word4", 256'(req_addrs.size()), 256'(4));
        rst_n = 1'b0;
        bus.c_strobe_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("abort_quiet_%0d", i), {bus.w_req_o, bus.c_ready_o}, '0);
        end
        rst_n = 1'b1;
        repeat (4) step();
        check("abort_no_ready", 256'(ready_cnt), 256'(0));
        fill(32'h8000_0020, 32'h8000_0020, 17, 1'b1, "after_abort");
`ifdef ICACHE_FILL_STATS_EN
        check("stats_fill_cnt", 256'(fill_cnt), 256'(1));
        check("stats_stall_cnt", 256'(stall_cnt), 256'(2 * WORDS));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
